// File: rtl/serial_loader_8bits.sv
// serial_loader_8bits
//   Assembles a qualified serial bit stream into a parallel word and hands it
//   to the downstream holding register as a one-cycle load strobe plus data.
//   A frame is a start strobe, DATA_WIDTH qualified data bits, and (when
//   SERIAL_LOADER_PARITY_EN is defined) one trailing even-parity bit.
//
// Build option:
//   SERIAL_LOADER_PARITY_EN  defined   -> parity bit checked, parity_err strobes
//                            undefined -> no parity bit, parity_err tied low
//
// Ports:
//   clock           in   rising-edge clock
//   clear_n         in   asynchronous active-low reset
//   start           in   begins or restarts a frame (wins over serial_valid)
//   serial_in       in   data bit, sampled only when serial_valid=1
//   serial_valid    in   qualifies serial_in this cycle
//   load            out  one-cycle strobe, register_input holds a new word
//   register_input  out  last accepted word, held between strobes
//   busy            out  frame in progress (SHIFT or PARITY)
//   parity_err      out  one-cycle strobe on parity mismatch
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; serial_valid ignored
// SHIFT  | collecting data bits; stalls while serial_valid=0
// PARITY | waiting for the parity bit (parity build only)
// DONE   | single cycle; load or parity_err is presented here

module serial_loader_8bits #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  start,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  output logic                  load,
  output logic [DATA_WIDTH-1:0] register_input,
  output logic                  busy,
  output logic                  parity_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] sh_next;
  logic [CW-1:0]         count;

`ifdef SERIAL_LOADER_PARITY_EN
  logic perr_q;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // Word as it will look once the current serial_in is accepted.
  always_comb begin
    sh_next = sh;
    if (MSB_FIRST)
      sh_next = {sh[DATA_WIDTH-2:0], serial_in};
    else
      sh_next = {serial_in, sh[DATA_WIDTH-1:1]};
  end

  // load/register_input/busy are registered on the edge that enters DONE, so
  // they are valid during the DONE cycle itself.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state          <= IDLE;
      sh             <= '0;
      count          <= '0;
      load           <= 1'b0;
      register_input <= '0;
      busy           <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
      perr_q         <= 1'b0;
`endif
    end else begin
      load <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            count <= '0;
            sh    <= '0;
            busy  <= 1'b1;
          end
        end

        SHIFT: begin
          if (start) begin
            // Abort: the bit presented alongside start is discarded.
            count <= '0;
            sh    <= '0;
          end else if (serial_valid) begin
            sh    <= sh_next;
            count <= count + CW'(1);
            if (count == LAST_BIT) begin
`ifdef SERIAL_LOADER_PARITY_EN
              state <= PARITY;
`else
              state          <= DONE;
              load           <= 1'b1;
              register_input <= sh_next;
              busy           <= 1'b0;
`endif
            end
          end
        end

        PARITY: begin
`ifdef SERIAL_LOADER_PARITY_EN
          if (start) begin
            state <= SHIFT;
            count <= '0;
            sh    <= '0;
          end else if (serial_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            // Even parity: word plus parity bit must have an even number of ones.
            if ((^{sh, serial_in}) == 1'b0) begin
              load           <= 1'b1;
              register_input <= sh;
            end else begin
              perr_q <= 1'b1;
            end
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end

        DONE: begin
          if (start) begin
            state <= SHIFT;
            count <= '0;
            sh    <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
